// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and register-address types
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - writeback/decode bundle between the pipeline and the register file
interface reg_file_sb_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic              wb_reg_en;
    logic [ADDR_W-1:0] wb_reg_waddr;
    logic [DATA_W-1:0] wb_reg_wdata;

    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_dst_en;
    logic [ADDR_W-1:0] id_dst_addr;
    logic              id_issue;
    logic              id_stall;

    logic              sb_err;

    modport master (
        output wb_reg_en, wb_reg_waddr, wb_reg_wdata,
        output rf_raddr1, rf_raddr2,
        output id_rs1_used, id_rs2_used, id_dst_en, id_dst_addr, id_issue,
        input  rf_rdata1, rf_rdata2, id_stall, sb_err
    );

    modport slave (
        input  wb_reg_en, wb_reg_waddr, wb_reg_wdata,
        input  rf_raddr1, rf_raddr2,
        input  id_rs1_used, id_rs2_used, id_dst_en, id_dst_addr, id_issue,
        output rf_rdata1, rf_rdata2, id_stall, sb_err
    );

endinterface

// File: rtl/reg_file_core.sv
// rtl/reg_file_core.sv - register storage with two write-first bypassed read ports
module reg_file_core #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    import cpu_pkg::*;

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [NREG];
    logic              wr;

    // Register 0 is hardwired: its write enable is simply never raised.
    assign wr = we && (waddr != ZERO_ADDR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem[raddr1];
        if (raddr1 == ZERO_ADDR) begin
            rdata1 = '0;
        end else if (wr && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem[raddr2];
        if (raddr2 == ZERO_ADDR) begin
            rdata2 = '0;
        end else if (wr && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register write-pending scoreboard and decode stall
module reg_file_sb #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic         clk,
    input  logic         resetn,
    reg_file_sb_if.slave bus
);
    import cpu_pkg::*;

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
    localparam logic [CNT_W-1:0]  PEND_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pend     [NREG];
    logic [CNT_W-1:0] pend_nxt [NREG];

    logic wb_hit;
    logic hazard1;
    logic hazard2;
    logic struct_hold;
    logic stall;
    logic inc;
    logic err_set;
    logic sb_err_q;

    reg_file_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .we     (bus.wb_reg_en),
        .waddr  (bus.wb_reg_waddr),
        .wdata  (bus.wb_reg_wdata),
        .raddr1 (bus.rf_raddr1),
        .raddr2 (bus.rf_raddr2),
        .rdata1 (bus.rf_rdata1),
        .rdata2 (bus.rf_rdata2)
    );

    assign wb_hit = bus.wb_reg_en && (bus.wb_reg_waddr != ZERO_ADDR);

    // A last outstanding write landing this cycle is covered by the bypass path.
    always_comb begin
        hazard1 = bus.id_rs1_used && (pend[bus.rf_raddr1] != '0);
        if (pend[bus.rf_raddr1] == PEND_ONE && wb_hit && bus.wb_reg_waddr == bus.rf_raddr1) begin
            hazard1 = 1'b0;
        end
        hazard2 = bus.id_rs2_used && (pend[bus.rf_raddr2] != '0);
        if (pend[bus.rf_raddr2] == PEND_ONE && wb_hit && bus.wb_reg_waddr == bus.rf_raddr2) begin
            hazard2 = 1'b0;
        end
        struct_hold = bus.id_dst_en && (pend[bus.id_dst_addr] == PEND_MAX)
                      && !(bus.wb_reg_en && bus.wb_reg_waddr == bus.id_dst_addr);
    end

    assign stall   = bus.id_issue && (hazard1 || hazard2 || struct_hold);
    assign inc     = bus.id_issue && !stall && bus.id_dst_en && (bus.id_dst_addr != ZERO_ADDR);
    assign err_set = wb_hit && (pend[bus.wb_reg_waddr] == '0)
                     && !(inc && bus.id_dst_addr == bus.wb_reg_waddr);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_nxt[r] = pend[r];
            if (r != 0) begin
                if (inc && bus.id_dst_addr == ADDR_W'(r)) begin
                    if (!(wb_hit && bus.wb_reg_waddr == ADDR_W'(r))) begin
                        pend_nxt[r] = pend[r] + PEND_ONE;
                    end
                end else if (wb_hit && bus.wb_reg_waddr == ADDR_W'(r) && pend[r] != '0) begin
                    pend_nxt[r] = pend[r] - PEND_ONE;
                end
            end else begin
                pend_nxt[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= pend_nxt[r];
            end
            if (err_set) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign bus.id_stall = stall;
    assign bus.sb_err   = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with directed vectors
module tb_reg_file_sb;

    localparam int S_RD1   = 0;
    localparam int S_RD2   = 1;
    localparam int S_STALL = 2;
    localparam int S_ERR   = 3;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    bit   done;
    exp_t sbq[$];

    reg_file_sb_if bus ();

    reg_file_sb dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_RD1:   return bus.rf_rdata1;
            S_RD2:   return bus.rf_rdata2;
            S_STALL: return {31'd0, bus.id_stall};
            default: return {31'd0, bus.sb_err};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sbq.pop_front();
            act = sample(e.sig);
            checks = checks + 1;
            if (act !== e.val) begin
                errors = errors + 1;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        done = 1'b0;
        #20000;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL watchdog: test did not complete in time");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_reg_en    = 1'b0;
        bus.wb_reg_waddr = '0;
        bus.wb_reg_wdata = '0;
        bus.rf_raddr1    = '0;
        bus.rf_raddr2    = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2_used  = 1'b0;
        bus.id_dst_en    = 1'b0;
        bus.id_dst_addr  = '0;
        bus.id_issue     = 1'b0;
    endtask

    task automatic expect_val(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic check_now(input string n, input int s, input logic [31:0] v);
        logic [31:0] act;
        act = sample(s);
        checks = checks + 1;
        if (act !== v) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", n, act, v);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_reg_en    = 1'b1;
        bus.wb_reg_waddr = a;
        bus.wb_reg_wdata = d;
    endtask

    task automatic issue_dst(input logic [4:0] a);
        bus.id_issue    = 1'b1;
        bus.id_dst_en   = 1'b1;
        bus.id_dst_addr = a;
    endtask

    task automatic issue_rs1(input logic [4:0] a);
        bus.id_issue    = 1'b1;
        bus.id_rs1_used = 1'b1;
        bus.rf_raddr1   = a;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        tick(); idle();
        bus.rf_raddr1 = 5'd5; bus.rf_raddr2 = 5'd0;
        #1;
        check_now("rst_rd_r5_now", S_RD1, 32'h0);
        check_now("rst_rd_r0_now", S_RD2, 32'h0);
        expect_val("rst_rd_r5", S_RD1, 32'h0);
        expect_val("rst_rd_r0", S_RD2, 32'h0);
        expect_val("rst_stall", S_STALL, 32'h0);
        expect_val("rst_err", S_ERR, 32'h0);

        tick(); idle(); issue_dst(5'd5);
        expect_val("dst_r5_accept", S_STALL, 32'h0);
        tick(); idle(); wb(5'd5, 32'hDEADBEEF); bus.rf_raddr1 = 5'd5;
        expect_val("bypass_r5", S_RD1, 32'hDEADBEEF);
        tick(); idle(); bus.rf_raddr1 = 5'd5;
        expect_val("stored_r5", S_RD1, 32'hDEADBEEF);
        expect_val("no_err_r5", S_ERR, 32'h0);

        tick(); idle(); wb(5'd0, 32'h1234);
        expect_val("r0_bypass_p1", S_RD1, 32'h0);
        expect_val("r0_bypass_p2", S_RD2, 32'h0);
        tick(); idle();
        expect_val("r0_stored", S_RD2, 32'h0);
        expect_val("r0_no_err", S_ERR, 32'h0);

        tick(); idle(); issue_dst(5'd3);
        expect_val("dst_r3_accept", S_STALL, 32'h0);
        tick(); idle(); issue_rs1(5'd3);
        expect_val("raw1_stall_a", S_STALL, 32'h1);
        tick(); idle(); issue_rs1(5'd3);
        expect_val("raw1_stall_b", S_STALL, 32'h1);
        tick(); idle(); issue_rs1(5'd3); wb(5'd3, 32'h55);
        expect_val("raw1_release", S_STALL, 32'h0);
        expect_val("raw1_bypass", S_RD1, 32'h55);
        tick(); idle(); issue_rs1(5'd3);
        expect_val("raw1_drained", S_STALL, 32'h0);
        expect_val("raw1_stored", S_RD1, 32'h55);

        tick(); idle(); issue_dst(5'd4);
        expect_val("dst_r4_accept", S_STALL, 32'h0);
        tick(); idle(); bus.id_issue = 1'b1; bus.id_rs2_used = 1'b1; bus.rf_raddr2 = 5'd4;
        expect_val("raw2_stall", S_STALL, 32'h1);
        tick(); idle(); bus.id_issue = 1'b1; bus.id_rs2_used = 1'b1; bus.rf_raddr2 = 5'd4;
        wb(5'd4, 32'hA5A5A5A5);
        expect_val("raw2_release", S_STALL, 32'h0);
        expect_val("raw2_bypass", S_RD2, 32'hA5A5A5A5);

        for (int i = 0; i < 3; i++) begin
            tick(); idle(); issue_dst(5'd7);
            expect_val("r7_fill", S_STALL, 32'h0);
        end
        tick(); idle(); issue_dst(5'd7);
        expect_val("r7_full_hold", S_STALL, 32'h1);
        tick(); idle(); issue_dst(5'd7); wb(5'd7, 32'h77);
        expect_val("r7_full_wb_accept", S_STALL, 32'h0);
        tick(); idle(); issue_dst(5'd7);
        expect_val("r7_still_full", S_STALL, 32'h1);
        tick(); idle(); issue_rs1(5'd7); wb(5'd7, 32'h78);
        expect_val("r7_raw_pend3", S_STALL, 32'h1);
        expect_val("r7_bypass_78", S_RD1, 32'h78);
        tick(); idle(); wb(5'd7, 32'h79);
        tick(); idle(); issue_rs1(5'd7); wb(5'd7, 32'h7A);
        expect_val("r7_last_bypass", S_STALL, 32'h0);
        expect_val("r7_bypass_7a", S_RD1, 32'h7A);
        expect_val("r7_no_err", S_ERR, 32'h0);

        tick(); idle(); wb(5'd9, 32'h99); bus.rf_raddr2 = 5'd9;
        expect_val("uf_bypass", S_RD2, 32'h99);
        expect_val("uf_err_before_edge", S_ERR, 32'h0);
        tick(); idle(); bus.rf_raddr2 = 5'd9;
        expect_val("uf_stored", S_RD2, 32'h99);
        expect_val("uf_err_set", S_ERR, 32'h1);
        tick(); idle(); bus.id_issue = 1'b1; bus.id_rs2_used = 1'b1; bus.rf_raddr2 = 5'd9;
        expect_val("uf_pend_zero", S_STALL, 32'h0);
        tick(); idle();
        expect_val("uf_err_sticky", S_ERR, 32'h1);

        tick(); idle(); issue_dst(5'd3);
        tick(); idle(); issue_dst(5'd3);
        tick(); idle(); issue_rs1(5'd3); bus.rf_raddr2 = 5'd9;
        expect_val("pre_rst_stall", S_STALL, 32'h1);
        expect_val("pre_rst_rd1", S_RD1, 32'h55);
        expect_val("pre_rst_rd2", S_RD2, 32'h99);
        expect_val("pre_rst_err", S_ERR, 32'h1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_now("async_rst_rd1", S_RD1, 32'h0);
        check_now("async_rst_rd2", S_RD2, 32'h0);
        check_now("async_rst_stall", S_STALL, 32'h0);
        check_now("async_rst_err", S_ERR, 32'h0);
        tick(); resetn = 1'b1; idle();

        tick(); idle(); wb(5'd3, 32'h33);
        expect_val("post_rst_err_clear", S_ERR, 32'h0);
        tick(); idle();
        expect_val("post_rst_err_set", S_ERR, 32'h1);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
